// File: rtl/mux16_rr_sched_pkg.sv
// Shared constants and FSM state encoding for the 16-way round-robin mux scheduler.
package mux16_rr_sched_pkg;

    localparam int N_REQ  = 16;
    localparam int SEL_W  = 4;
    localparam int HOLD_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/mux16_rr_pick.sv
// Round-robin pick: lowest requester at or above ptr, wrapping modulo 16.
// Rotate so ptr lands on bit 0, fixed-priority encode, then add ptr back.
module mux16_rr_pick
    import mux16_rr_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [N_REQ-1:0] w_rot;
    logic [SEL_W-1:0] w_off;

    assign w_rot = N_REQ'({req, req} >> ptr);

    always_comb begin
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SEL_W'(i);
            end
        end
    end

    // Four-bit add wraps naturally, undoing the rotation modulo 16.
    assign idx   = w_off + ptr;
    assign found = |req;

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler in front of a 16:1 single-bit mux: registered one-hot grant,
// select, routed data bit and a hold counter that forces rotation after MAX_HOLD cycles.
//   state    | meaning
//   ST_IDLE  | no grant held, outputs cleared
//   ST_GRANT | one requester owns the mux, gnt/sel/data_out valid
module mux16_rr_sched
    import mux16_rr_sched_pkg::N_REQ;
    import mux16_rr_sched_pkg::HOLD_W;
    import mux16_rr_sched_pkg::state_e;
    import mux16_rr_sched_pkg::ST_IDLE;
    import mux16_rr_sched_pkg::ST_GRANT;
#(
    parameter int N        = 16,
    parameter int SEL_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      data_in,
    output logic [N-1:0]      gnt,
    output logic [SEL_W-1:0]  sel,
    output logic              gnt_valid,
    output logic              data_out,
    output logic [HOLD_W-1:0] hold_cnt
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    state_e            r_state, w_state_nxt;
    logic [N-1:0]      r_gnt, w_gnt_nxt;
    logic [SEL_W-1:0]  r_sel, w_sel_nxt;
    logic [SEL_W-1:0]  r_ptr, w_ptr_nxt;
    logic              r_gnt_valid, w_valid_nxt;
    logic              r_data_out, w_dout_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;

    logic [SEL_W-1:0]  w_pick_ptr;
    logic [SEL_W-1:0]  w_pick_idx;
    logic              w_found;
    logic              w_cur_req;
    logic              w_others;
    logic              w_rotate;

    // While granted, the search always starts just past the owner so it gets lowest priority.
    assign w_pick_ptr = (r_state == ST_GRANT) ? r_sel + 1'b1 : r_ptr;
    assign w_cur_req  = req[r_sel];
    assign w_others   = |(req & ~r_gnt);
    assign w_rotate   = !w_cur_req || ((r_hold == MAX_HOLD_C) && w_others);

    mux16_rr_pick u_pick (
        .req   (req),
        .ptr   (w_pick_ptr),
        .idx   (w_pick_idx),
        .found (w_found)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = '0;
        w_sel_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_hold_nxt  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = N'(1) << w_pick_idx;
                    w_sel_nxt   = w_pick_idx;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = HOLD_W'(1);
                end
            end
            ST_GRANT: begin
                if (w_rotate) begin
                    w_ptr_nxt = w_pick_ptr;
                    if (w_found) begin
                        w_gnt_nxt   = N'(1) << w_pick_idx;
                        w_sel_nxt   = w_pick_idx;
                        w_valid_nxt = 1'b1;
                        w_hold_nxt  = HOLD_W'(1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_gnt_nxt   = r_gnt;
                    w_sel_nxt   = r_sel;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = (r_hold < MAX_HOLD_C) ? r_hold + 1'b1 : r_hold;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_dout_nxt = w_valid_nxt & data_in[w_sel_nxt];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_sel       <= '0;
            r_gnt_valid <= 1'b0;
            r_data_out  <= 1'b0;
            r_hold      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt       <= w_gnt_nxt;
            r_sel       <= w_sel_nxt;
            r_gnt_valid <= w_valid_nxt;
            r_data_out  <= w_dout_nxt;
            r_hold      <= w_hold_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign gnt_valid = r_gnt_valid;
    assign data_out  = r_data_out;
    assign hold_cnt  = r_hold;

`ifndef SYNTHESIS
    a_req_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(req));
`endif

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Bench for mux16_rr_sched: directed scenarios plus randomized traffic against an
// arbitration model built from owner index, pointer and hold count.
module tb_mux16_rr_sched;

    localparam int MAXH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = '0;
    logic [15:0] data_in = '0;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        gnt_valid;
    logic        data_out;
    logic [7:0]  hold_cnt;

    int n_total = 0;
    int n_pass  = 0;

    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_hold  = 0;
    logic m_dout  = 1'b0;

    mux16_rr_sched #(.N(16), .SEL_W(4), .MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .gnt       (gnt),
        .sel       (sel),
        .gnt_valid (gnt_valid),
        .data_out  (data_out),
        .hold_cnt  (hold_cnt)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [15:0] r, input int p);
        for (int k = 0; k < 16; k++) begin
            if (r[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    // Drive one cycle, let the edge happen, sample 1 ns later and advance the model.
    task automatic cycle(input logic rst_v, input logic [15:0] r, input logic [15:0] d);
        logic [15:0] others;
        rst_n   = rst_v;
        req     = r;
        data_in = d;
        @(posedge clk);
        #1;
        if (!rst_v) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            m_owner = pick(r, m_ptr);
            m_hold  = (m_owner >= 0) ? 1 : 0;
        end else begin
            others = r;
            others[m_owner] = 1'b0;
            if (!r[m_owner] || (m_hold == MAXH && others != 0)) begin
                m_ptr   = (m_owner + 1) % 16;
                m_owner = pick(r, m_ptr);
                m_hold  = (m_owner >= 0) ? 1 : 0;
            end else if (m_hold < MAXH) begin
                m_hold++;
            end
        end
        m_dout = (m_owner >= 0) ? d[m_owner] : 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 16'hFFFF, 16'hFFFF);
            n_total++;
            if ({gnt, sel, gnt_valid, data_out, hold_cnt} !== 30'd0)
                $display("FAIL reset_hold_%0d: got gnt=%h sel=%0d valid=%b dout=%b hold=%0d, expected all zero",
                         i, gnt, sel, gnt_valid, data_out, hold_cnt);
            else n_pass++;
        end
        cycle(1'b1, 16'hFFFF, 16'h0000);
        n_total++;
        if ({gnt, sel, gnt_valid, hold_cnt} !== {16'h0001, 4'd0, 1'b1, 8'd1})
            $display("FAIL reset_first_grant: got gnt=%h sel=%0d valid=%b hold=%0d, expected gnt=0001 sel=0 valid=1 hold=1",
                     gnt, sel, gnt_valid, hold_cnt);
        else n_pass++;
    endtask

    task automatic test_single();
        int exp_hold;
        cycle(1'b0, 16'h0000, 16'h0000);
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b1, 16'h0020, 16'hAAAA);
            exp_hold = (k < MAXH) ? k : MAXH;
            n_total++;
            if ({gnt, sel, gnt_valid, data_out} !== {16'h0020, 4'd5, 1'b1, 1'b1})
                $display("FAIL single_grant_%0d: got gnt=%h sel=%0d valid=%b dout=%b, expected gnt=0020 sel=5 valid=1 dout=1",
                         k, gnt, sel, gnt_valid, data_out);
            else n_pass++;
            n_total++;
            if (hold_cnt !== 8'(exp_hold))
                $display("FAIL single_hold_%0d: got hold=%0d, expected %0d", k, hold_cnt, exp_hold);
            else n_pass++;
        end
    endtask

    task automatic test_fairness();
        int exp_sel;
        int exp_hold;
        cycle(1'b0, 16'h0000, 16'h0000);
        for (int k = 1; k <= 40; k++) begin
            cycle(1'b1, 16'h8001, 16'($urandom));
            exp_sel  = (((k - 1) / MAXH) % 2 == 0) ? 0 : 15;
            exp_hold = ((k - 1) % MAXH) + 1;
            n_total++;
            if ({gnt, sel, gnt_valid, hold_cnt} !== {16'(1) << exp_sel, 4'(exp_sel), 1'b1, 8'(exp_hold)})
                $display("FAIL fairness_%0d: got gnt=%h sel=%0d valid=%b hold=%0d, expected sel=%0d valid=1 hold=%0d",
                         k, gnt, sel, gnt_valid, hold_cnt, exp_sel, exp_hold);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 16'h0000, 16'h0000);
        cycle(1'b1, 16'h8000, 16'h0000);
        n_total++;
        if ({sel, gnt_valid} !== {4'd15, 1'b1})
            $display("FAIL wrap_grant15: got sel=%0d valid=%b, expected sel=15 valid=1", sel, gnt_valid);
        else n_pass++;
        cycle(1'b1, 16'h0001, 16'h0001);
        n_total++;
        if ({gnt, sel, gnt_valid, data_out, hold_cnt} !== {16'h0001, 4'd0, 1'b1, 1'b1, 8'd1})
            $display("FAIL wrap_release: got gnt=%h sel=%0d valid=%b dout=%b hold=%0d, expected gnt=0001 sel=0 valid=1 dout=1 hold=1",
                     gnt, sel, gnt_valid, data_out, hold_cnt);
        else n_pass++;
        // Leave the pointer parked at 15 while idle, then request 0 and 15 together.
        cycle(1'b0, 16'h0000, 16'h0000);
        cycle(1'b1, 16'h4000, 16'h0000);
        cycle(1'b1, 16'h0000, 16'h0000);
        n_total++;
        if ({gnt, gnt_valid} !== {16'h0000, 1'b0})
            $display("FAIL wrap_idle: got gnt=%h valid=%b, expected gnt=0000 valid=0", gnt, gnt_valid);
        else n_pass++;
        cycle(1'b1, 16'h8001, 16'h0000);
        n_total++;
        if ({gnt, sel} !== {16'h8000, 4'd15})
            $display("FAIL wrap_ptr15: got gnt=%h sel=%0d, expected gnt=8000 sel=15", gnt, sel);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        cycle(1'b0, 16'h0000, 16'h0000);
        cycle(1'b1, 16'h0008, 16'h0008);
        n_total++;
        if ({sel, gnt_valid, data_out} !== {4'd3, 1'b1, 1'b1})
            $display("FAIL b2b_grant3: got sel=%0d valid=%b dout=%b, expected sel=3 valid=1 dout=1", sel, gnt_valid, data_out);
        else n_pass++;
        cycle(1'b1, 16'h0410, 16'h0400);
        n_total++;
        if ({gnt, sel, gnt_valid, data_out, hold_cnt} !== {16'h0010, 4'd4, 1'b1, 1'b0, 8'd1})
            $display("FAIL b2b_to4: got gnt=%h sel=%0d valid=%b dout=%b hold=%0d, expected gnt=0010 sel=4 valid=1 dout=0 hold=1",
                     gnt, sel, gnt_valid, data_out, hold_cnt);
        else n_pass++;
        cycle(1'b1, 16'h0400, 16'h0400);
        n_total++;
        if ({gnt, sel, gnt_valid, data_out} !== {16'h0400, 4'd10, 1'b1, 1'b1})
            $display("FAIL b2b_to10: got gnt=%h sel=%0d valid=%b dout=%b, expected gnt=0400 sel=10 valid=1 dout=1",
                     gnt, sel, gnt_valid, data_out);
        else n_pass++;
        cycle(1'b1, 16'h0000, 16'hFFFF);
        n_total++;
        if ({gnt, sel, gnt_valid, data_out, hold_cnt} !== 30'd0)
            $display("FAIL b2b_drop_all: got gnt=%h sel=%0d valid=%b dout=%b hold=%0d, expected all zero",
                     gnt, sel, gnt_valid, data_out, hold_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 16'h0000, 16'h0000);
        for (int k = 0; k < 5; k++) cycle(1'b1, 16'h0080, 16'h0080);
        n_total++;
        if ({sel, hold_cnt} !== {4'd7, 8'd5})
            $display("FAIL midrst_pre: got sel=%0d hold=%0d, expected sel=7 hold=5", sel, hold_cnt);
        else n_pass++;
        cycle(1'b0, 16'h0080, 16'h0080);
        n_total++;
        if ({gnt, sel, gnt_valid, data_out, hold_cnt} !== 30'd0)
            $display("FAIL midrst_clear: got gnt=%h sel=%0d valid=%b dout=%b hold=%0d, expected all zero",
                     gnt, sel, gnt_valid, data_out, hold_cnt);
        else n_pass++;
        cycle(1'b1, 16'h0080, 16'h0080);
        n_total++;
        if ({gnt, sel, gnt_valid, data_out, hold_cnt} !== {16'h0080, 4'd7, 1'b1, 1'b1, 8'd1})
            $display("FAIL midrst_regrant: got gnt=%h sel=%0d valid=%b dout=%b hold=%0d, expected gnt=0080 sel=7 valid=1 dout=1 hold=1",
                     gnt, sel, gnt_valid, data_out, hold_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] r;
        logic [15:0] exp_gnt;
        logic [3:0]  exp_sel;
        logic        rst_v;
        int          mode;
        r = '0;
        cycle(1'b0, 16'h0000, 16'h0000);
        for (int n = 0; n < 600; n++) begin
            mode = int'($urandom_range(0, 9));
            if (mode == 0)      r = '0;
            else if (mode <= 2) r = 16'(1) << $urandom_range(0, 15);
            else if (mode <= 4) r = 16'($urandom);
            rst_v = ($urandom_range(0, 79) != 0);
            cycle(rst_v, r, 16'($urandom));
            exp_gnt = (m_owner >= 0) ? (16'(1) << m_owner) : 16'h0000;
            exp_sel = (m_owner >= 0) ? 4'(m_owner) : 4'd0;
            n_total++;
            if ({gnt, sel, gnt_valid, data_out, hold_cnt} !==
                {exp_gnt, exp_sel, (m_owner >= 0), m_dout, 8'(m_hold)})
                $display("FAIL random_%0d: got gnt=%h sel=%0d valid=%b dout=%b hold=%0d, expected gnt=%h sel=%0d valid=%b dout=%b hold=%0d",
                         n, gnt, sel, gnt_valid, data_out, hold_cnt,
                         exp_gnt, exp_sel, (m_owner >= 0), m_dout, m_hold);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux16_rr_sched.md
Name: mux16_rr_sched

Overview:
Round-robin scheduler that shares one 16-to-1 single-bit mux among 16 requesters. It registers a one-hot grant and a 4-bit select, and routes the granted requester's data bit to a registered output. A per-grant hold limit prevents starvation. It sits directly in front of the mux16to1 datapath and drives its select.

Parameters:
N, 16, number of requesters; fixed at 16 for this revision.
SEL_W, 4, select width; must equal log2(N).
MAX_HOLD, 8, maximum consecutive cycles one requester may keep the grant while others are waiting; legal range 1..255.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous reset, active-low.
req  input  16  request vector; bit i is requester i.
data_in  input  16  data bit per requester.
gnt  output  16  one-hot grant; all zero when idle.
sel  output  4  mux select; index of the granted requester.
gnt_valid  output  1  high while a grant is held.
data_out  output  1  data_in[sel] registered while gnt_valid; 0 otherwise.
hold_cnt  output  8  cycles the current grant has been held; saturates at MAX_HOLD.

Behaviour:
- Reset (rst_n low at a clk edge):
  - gnt=0, sel=0, gnt_valid=0, data_out=0, hold_cnt=0.
  - Rotation pointer ptr=0; state=IDLE.
  - Reset overrides everything, including mid-grant; the grant drops on the same edge.
- All outputs are registered. A grant becomes visible 1 cycle after the req edge that caused it.
- Pick function (rr_pick): returns the lowest index i ≥ ptr, wrapping modulo 16, with req[i]=1. It also returns a found flag. Purely combinational.
- State IDLE:
  - found=0: stay in IDLE, outputs 0.
  - found=1: go to GRANT. Set gnt=1<<i, sel=i, gnt_valid=1, hold_cnt=1.
- State GRANT, evaluated each cycle on the current req:
  - Release: req[sel]=0.
    - Set ptr=sel+1 mod 16.
    - If another requester is found from the new ptr, grant it back-to-back with no idle cycle; hold_cnt=1.
    - Otherwise go to IDLE and clear the outputs.
  - Preempt: req[sel]=1, hold_cnt==MAX_HOLD, and any other req bit set.
    - Set ptr=sel+1; grant the pick from that ptr. It cannot be sel because another requester is waiting.
    - hold_cnt=1.
  - Continue: otherwise keep the grant; hold_cnt=min(hold_cnt+1, MAX_HOLD).
- data_out is registered from data_in[sel_next] on the cycle the grant is issued or continued. It is therefore aligned with gnt/sel, and is 0 in IDLE.
- Invariants:
  - gnt is one-hot or zero.
  - gnt_valid equals |gnt.
  - When gnt_valid=1, gnt[sel]=1.
- Wrap-around: ptr=15 with a request only at bit 0 grants 0.
- Simultaneous release and new request at the same index: the released index has lowest priority (ptr has advanced past it). It is re-granted only if it is the sole requester.
- X on req is not supported; a simulation-only assertion flags it.

Decomposition:
- Shared include file holds:
  - Constants N_REQ=16, SEL_W=4, HOLD_W=8.
  - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
- One sub-module: mux16_rr_pick. Inputs req[15:0] and ptr[3:0]; outputs idx[3:0] and found. Built as a rotate, fixed-priority encode, un-rotate.
- The top holds the FSM, ptr, hold counter and output registers.

Test Plan:
- Reset: drive req=16'hFFFF with rst_n=0 for 3 cycles → gnt=0, sel=0, gnt_valid=0, hold_cnt=0 throughout; first grant after release is gnt=16'h0001, sel=0, one cycle later.
- Single requester, data path: req=16'h0020, data_in=16'hAAAA → next cycle sel=5, gnt=16'h0020, data_out=1. hold_cnt counts 1..8 then stays at 8; no preemption.
- Round-robin fairness: req=16'h8001 held constant, MAX_HOLD=8 → grant alternates between 0 and 15 every 8 cycles; sel sequence 0,15,0,…; never a gap cycle.
- Wrap-around: grant 15, then drop req[15] while req=16'h0001 → next cycle sel=0, hold_cnt=1, gnt_valid stays 1.
- Back-to-back release: grant 3, then req changes 16'h0008→16'h0410 → next cycle sel=4. Drop req[4] → sel=10. Drop all → gnt_valid=0 the cycle after.
- Reset mid-grant: grant 7 with hold_cnt=5, pulse rst_n=0 for one cycle → outputs clear on that edge. After release with req=16'h0080, grant 7 reappears with hold_cnt=1 (ptr back to 0).
